// File: rtl/ttl_pkg.sv
// Shared definitions for receivers sitting on multiplexed 4-bit TTL buses:
// nibble-assembly FSM encoding, default settle time and a word-join helper.
package ttl_pkg;

    typedef enum logic {
        EXPECT_LO = 1'b0,
        EXPECT_HI = 1'b1
    } rx_state_e;

    localparam int unsigned SETTLE_DEFAULT = 2;

    function automatic logic [7:0] join_nibbles(input logic [3:0] hi, input logic [3:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/settle_timer.sv
// Tracks how long the transmitter's select line has been stable and reports
// when the multiplexed bus may be sampled.
module settle_timer #(
    parameter int unsigned SETTLE = ttl_pkg::SETTLE_DEFAULT
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic sel_i,
    output logic settled_o
);

    localparam int unsigned CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [CW-1:0] LOAD = CW'(SETTLE);

    logic          sel_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] eff;
    logic          change;

    // A change seen this cycle counts as the first settle cycle, so the bus is
    // usable exactly SETTLE cycles after the select line moved.
    always_comb begin
        change    = (sel_i != sel_q);
        eff       = change ? LOAD : cnt_q;
        settled_o = (eff == '0);
        cnt_d     = settled_o ? '0 : eff - CW'(1);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sel_q <= 1'b0;
            cnt_q <= LOAD;
        end else begin
            sel_q <= sel_i;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/nibble_demux_rx.sv
// Receiver for the 74157-multiplexed nibble bus: settles, samples and pairs
// low/high nibbles into bytes presented through a one-entry output register.
module nibble_demux_rx
    import ttl_pkg::*;
#(
    parameter int unsigned SETTLE = SETTLE_DEFAULT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] bus,
    input  logic       mux_sel,
    input  logic       strobe,
    output logic [7:0] word,
    output logic       word_valid,
    input  logic       word_ready,
    output logic       seq_err,
    output logic       ovf_err,
    input  logic       err_clr,
    output rx_state_e  dbg_state_o
);

    logic settled;

    settle_timer #(
        .SETTLE(SETTLE)
    ) u_settle (
        .clk_i    (clk),
        .reset_ni (reset_n),
        .sel_i    (mux_sel),
        .settled_o(settled)
    );

    rx_state_e  state_q, state_d;
    logic [3:0] lo_q, lo_d;
    logic [7:0] word_q, word_d;
    logic       valid_q, valid_d;
    logic       seq_q, seq_d;
    logic       ovf_q, ovf_d;
    logic       pending_q, pending_d;
    logic       smp_vld_q, smp_vld_d;
    logic [3:0] smp_nib_q, smp_nib_d;
    logic       smp_sel_q, smp_sel_d;

    logic       take;
    logic       seq_set;
    logic       ovf_set;
    logic       complete;
    logic [7:0] new_word;

    // Sample stage: a strobe either lands now (bus settled) or waits as the
    // single pending request; a strobe on top of a pending one is an error.
    always_comb begin
        take      = settled & (strobe | pending_q);
        pending_d = pending_q;
        if (take) begin
            pending_d = 1'b0;
        end else if (strobe) begin
            pending_d = 1'b1;
        end
        smp_vld_d = take;
        smp_nib_d = take ? bus : smp_nib_q;
        smp_sel_d = take ? mux_sel : smp_sel_q;
    end

    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        seq_set  = strobe & pending_q;
        complete = 1'b0;
        new_word = join_nibbles(smp_nib_q, lo_q);
        if (smp_vld_q) begin
            unique case (state_q)
                EXPECT_LO: begin
                    if (!smp_sel_q) begin
                        lo_d    = smp_nib_q;
                        state_d = EXPECT_HI;
                    end else begin
                        seq_set = 1'b1;
                    end
                end
                EXPECT_HI: begin
                    if (smp_sel_q) begin
                        complete = 1'b1;
                        state_d  = EXPECT_LO;
                    end else begin
                        // A second low nibble restarts the pair with the newer value.
                        seq_set = 1'b1;
                        lo_d    = smp_nib_q;
                    end
                end
                default: state_d = EXPECT_LO;
            endcase
        end
    end

    // Output handshake: word is transferred on a cycle where word_valid and
    // word_ready are both high; a completion may refill the register in that
    // same cycle, otherwise a completion into a full register is dropped.
    always_comb begin
        word_d  = word_q;
        valid_d = valid_q;
        ovf_set = 1'b0;
        if (complete) begin
            if (!valid_q || word_ready) begin
                word_d  = new_word;
                valid_d = 1'b1;
            end else begin
                ovf_set = 1'b1;
            end
        end else if (valid_q && word_ready) begin
            valid_d = 1'b0;
        end
        seq_d = (seq_q & ~err_clr) | seq_set;
        ovf_d = (ovf_q & ~err_clr) | ovf_set;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= EXPECT_LO;
            lo_q      <= '0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            seq_q     <= 1'b0;
            ovf_q     <= 1'b0;
            pending_q <= 1'b0;
            smp_vld_q <= 1'b0;
            smp_nib_q <= '0;
            smp_sel_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lo_q      <= lo_d;
            word_q    <= word_d;
            valid_q   <= valid_d;
            seq_q     <= seq_d;
            ovf_q     <= ovf_d;
            pending_q <= pending_d;
            smp_vld_q <= smp_vld_d;
            smp_nib_q <= smp_nib_d;
            smp_sel_q <= smp_sel_d;
        end
    end

    assign word        = word_q;
    assign word_valid  = valid_q;
    assign seq_err     = seq_q;
    assign ovf_err     = ovf_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_nibble_demux_rx.sv
// Bench for nibble_demux_rx: one instance with SETTLE=0 and one with SETTLE=2
// share the stimulus and are both held against a timestamp-based model.
module tb_nibble_demux_rx;
    import ttl_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] bus = '0;
    logic       mux_sel = 1'b0;
    logic       strobe = 1'b0;
    logic       word_ready = 1'b0;
    logic       err_clr = 1'b0;

    logic [7:0] word_0, word_1;
    logic       valid_0, valid_1, seq_0, seq_1, ovf_0, ovf_1;
    rx_state_e  dbg_0, dbg_1;

    always #5 clk = ~clk;

    nibble_demux_rx #(.SETTLE(0)) u_d0 (
        .clk(clk), .reset_n(reset_n), .bus(bus), .mux_sel(mux_sel), .strobe(strobe),
        .word(word_0), .word_valid(valid_0), .word_ready(word_ready),
        .seq_err(seq_0), .ovf_err(ovf_0), .err_clr(err_clr), .dbg_state_o(dbg_0)
    );

    nibble_demux_rx #(.SETTLE(2)) u_d2 (
        .clk(clk), .reset_n(reset_n), .bus(bus), .mux_sel(mux_sel), .strobe(strobe),
        .word(word_1), .word_valid(valid_1), .word_ready(word_ready),
        .seq_err(seq_1), .ovf_err(ovf_1), .err_clr(err_clr), .dbg_state_o(dbg_1)
    );

    // Observed bundle per instance: {word, valid, seq_err, ovf_err, expecting_hi}
    logic [11:0] obs [2];
    assign obs[0] = {word_0, valid_0, seq_0, ovf_0, dbg_0 == EXPECT_HI};
    assign obs[1] = {word_1, valid_1, seq_1, ovf_1, dbg_1 == EXPECT_HI};

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- reference model ----------------
    int         m_cyc = 0;
    int         m_last_chg = 0;
    bit         m_fresh = 1'b1;
    logic       m_prev_sel = 1'b0;
    logic [7:0] m_wrd [2];
    logic [3:0] m_lo [2];
    logic [3:0] m_fnib [2];
    bit         m_vld [2];
    bit         m_seq [2];
    bit         m_ovf [2];
    bit         m_hi [2];
    bit         m_pend [2];
    bit         m_fl [2];
    bit         m_fsel [2];

    function automatic logic [11:0] mdl(input int i);
        return {m_wrd[i], m_vld[i], m_seq[i], m_ovf[i], m_hi[i]};
    endfunction

    task automatic model_reset();
        m_fresh = 1'b1;
        m_prev_sel = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_wrd[i] = '0; m_lo[i] = '0; m_fnib[i] = '0;
            m_vld[i] = 0; m_seq[i] = 0; m_ovf[i] = 0; m_hi[i] = 0;
            m_pend[i] = 0; m_fl[i] = 0; m_fsel[i] = 0;
        end
    endtask

    // The bus is usable once SETTLE whole cycles have passed since the last
    // select change (reset release counts as a change).
    task automatic model_step();
        bit         settled_now, seq_set, ovf_set, done;
        logic [7:0] new_word;
        if (m_fresh) begin
            m_last_chg = m_cyc;
            m_fresh = 1'b0;
        end
        if (mux_sel !== m_prev_sel) m_last_chg = m_cyc;
        for (int i = 0; i < 2; i++) begin
            settled_now = (m_cyc - m_last_chg) >= ((i == 0) ? 0 : 2);
            seq_set = strobe && m_pend[i];
            ovf_set = 0;
            done = 0;
            new_word = '0;
            if (m_fl[i]) begin
                if (!m_hi[i]) begin
                    if (!m_fsel[i]) begin m_lo[i] = m_fnib[i]; m_hi[i] = 1; end
                    else seq_set = 1;
                end else if (m_fsel[i]) begin
                    new_word = {m_fnib[i], m_lo[i]};
                    done = 1;
                    m_hi[i] = 0;
                end else begin
                    seq_set = 1;
                    m_lo[i] = m_fnib[i];
                end
            end
            if (done) begin
                if (!m_vld[i] || word_ready) begin m_wrd[i] = new_word; m_vld[i] = 1; end
                else ovf_set = 1;
            end else if (word_ready) begin
                m_vld[i] = 0;
            end
            m_seq[i] = (m_seq[i] && !err_clr) || seq_set;
            m_ovf[i] = (m_ovf[i] && !err_clr) || ovf_set;
            m_fl[i] = 0;
            if (settled_now && (strobe || m_pend[i])) begin
                m_fl[i] = 1; m_fnib[i] = bus; m_fsel[i] = mux_sel; m_pend[i] = 0;
            end else if (strobe) begin
                m_pend[i] = 1;
            end
        end
        m_prev_sel = mux_sel;
        m_cyc++;
    endtask

    always @(negedge reset_n) model_reset();
    always @(posedge clk) if (reset_n) model_step();

    // ---------------- driver ----------------
    logic [7:0] stim_q[$];

    function automatic logic [7:0] mk(input bit clr, input bit rdy, input bit stb,
                                      input bit sel, input logic [3:0] b);
        return {clr, rdy, stb, sel, b};
    endfunction

    task automatic add(input logic [7:0] v, input int n);
        repeat (n) stim_q.push_back(v);
    endtask

    task automatic apply(input logic [7:0] v);
        {err_clr, word_ready, strobe, mux_sel, bus} = v;
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        model_reset();
        {err_clr, word_ready, strobe, mux_sel, bus} = '0;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (obs[i] !== 12'h000) begin
                n_bad++;
                $display("FAIL reset inst%0d: got %h want 000", i, obs[i]);
            end
        end
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        int vcnt[2];
        logic [7:0] lastw[2];
        int n;
        vcnt = '{0, 0};
        lastw = '{8'h00, 8'h00};
        stim_q.delete();
        add(mk(0, 1, 0, 0, 4'h0), 4);
        add(mk(0, 1, 1, 0, 4'hA), 1);
        add(mk(0, 1, 1, 1, 4'h5), 1);
        add(mk(0, 1, 0, 1, 4'h5), 6);
        n = stim_q.size();
        for (int k = 0; k < n; k++) begin
            apply(stim_q[k]);
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (obs[i] !== mdl(i)) begin
                    n_bad++;
                    $display("FAIL basic_model inst%0d step%0d: got %h want %h", i, k, obs[i], mdl(i));
                end
                if (obs[i][3]) begin vcnt[i]++; lastw[i] = obs[i][11:4]; end
            end
            if (k == 5) begin
                n_cmp++;
                if (obs[0][0] !== 1'b1) begin
                    n_bad++;
                    $display("FAIL basic_state inst0: got %b want 1 (EXPECT_HI)", obs[0][0]);
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (vcnt[i] != 1 || lastw[i] !== 8'h5A || obs[i][2:1] !== 2'b00) begin
                n_bad++;
                $display("FAIL basic_word inst%0d: valid_cycles %0d word %h errs %b want 1 5a 00",
                         i, vcnt[i], lastw[i], obs[i][2:1]);
            end
        end
    endtask

    task automatic test_settle();
        int n;
        stim_q.delete();
        add(mk(0, 0, 0, 1, 4'h5), 3);
        add(mk(0, 0, 1, 0, 4'h7), 1);
        add(mk(0, 0, 0, 0, 4'h9), 1);
        add(mk(0, 0, 0, 0, 4'h4), 3);
        add(mk(0, 0, 1, 1, 4'h8), 1);
        add(mk(0, 0, 0, 1, 4'h8), 5);
        add(mk(0, 1, 0, 1, 4'h8), 3);
        n = stim_q.size();
        for (int k = 0; k < n; k++) begin
            apply(stim_q[k]);
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (obs[i] !== mdl(i)) begin
                    n_bad++;
                    $display("FAIL settle_model inst%0d step%0d: got %h want %h", i, k, obs[i], mdl(i));
                end
            end
            if (k == 5 || k == 6) begin
                n_cmp++;
                if (obs[1][0] !== (k == 6)) begin
                    n_bad++;
                    $display("FAIL settle_latency inst1 step%0d: hi_state %b want %b", k, obs[1][0], k == 6);
                end
            end
            if (k == 10) begin
                n_cmp++;
                if (obs[1][3] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL settle_early inst1: valid %b want 0", obs[1][3]);
                end
            end
            if (k == 11) begin
                n_cmp++;
                if (obs[1][11:3] !== {8'h84, 1'b1}) begin
                    n_bad++;
                    $display("FAIL settle_word inst1: got %h want 84 valid", obs[1][11:3]);
                end
                n_cmp++;
                if (obs[0][11:3] !== {8'h87, 1'b1}) begin
                    n_bad++;
                    $display("FAIL settle_word inst0: got %h want 87 valid", obs[0][11:3]);
                end
            end
        end
    endtask

    task automatic test_seq_err();
        int vcnt[2];
        logic [7:0] lastw[2];
        int n;
        vcnt = '{0, 0};
        lastw = '{8'h00, 8'h00};
        stim_q.delete();
        add(mk(0, 1, 0, 1, 4'h8), 3);
        add(mk(0, 1, 1, 1, 4'hF), 1);
        add(mk(0, 1, 0, 1, 4'hF), 3);
        add(mk(0, 1, 1, 0, 4'h3), 1);
        add(mk(0, 1, 0, 0, 4'h3), 3);
        add(mk(0, 1, 1, 1, 4'hC), 1);
        add(mk(0, 1, 0, 1, 4'hC), 4);
        n = stim_q.size();
        for (int k = 0; k < n; k++) begin
            apply(stim_q[k]);
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (obs[i] !== mdl(i)) begin
                    n_bad++;
                    $display("FAIL seq_model inst%0d step%0d: got %h want %h", i, k, obs[i], mdl(i));
                end
                if (obs[i][3]) begin vcnt[i]++; lastw[i] = obs[i][11:4]; end
            end
        end
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (vcnt[i] != 1 || lastw[i] !== 8'hC3 || obs[i][2] !== 1'b1) begin
                n_bad++;
                $display("FAIL seq_err inst%0d: valid_cycles %0d word %h seq %b want 1 c3 1",
                         i, vcnt[i], lastw[i], obs[i][2]);
            end
        end
    endtask

    task automatic test_overflow();
        int n;
        stim_q.delete();
        add(mk(1, 0, 0, 1, 4'hC), 1);
        add(mk(0, 0, 1, 0, 4'h1), 1);
        add(mk(0, 0, 0, 0, 4'h1), 3);
        add(mk(0, 0, 1, 1, 4'h1), 1);
        add(mk(0, 0, 0, 1, 4'h1), 3);
        add(mk(0, 0, 1, 0, 4'h2), 1);
        add(mk(0, 0, 0, 0, 4'h2), 3);
        add(mk(0, 0, 1, 1, 4'h2), 1);
        add(mk(0, 0, 0, 1, 4'h2), 4);
        add(mk(1, 0, 0, 1, 4'h2), 1);
        add(mk(0, 0, 0, 1, 4'h2), 1);
        add(mk(0, 1, 0, 1, 4'h2), 2);
        n = stim_q.size();
        for (int k = 0; k < n; k++) begin
            apply(stim_q[k]);
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (obs[i] !== mdl(i)) begin
                    n_bad++;
                    $display("FAIL ovf_model inst%0d step%0d: got %h want %h", i, k, obs[i], mdl(i));
                end
                if (k == 17) begin
                    n_cmp++;
                    if (obs[i][11:1] !== {8'h11, 3'b101}) begin
                        n_bad++;
                        $display("FAIL ovf_set inst%0d: got %h want 11 valid ovf", i, obs[i][11:1]);
                    end
                end
                if (k == 19) begin
                    n_cmp++;
                    if (obs[i][11:1] !== {8'h11, 3'b100}) begin
                        n_bad++;
                        $display("FAIL ovf_clear inst%0d: got %h want 11 valid no-ovf", i, obs[i][11:1]);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        stim_q.delete();
        add(mk(0, 0, 1, 0, 4'h6), 1);
        add(mk(0, 0, 0, 0, 4'h6), 3);
        add(mk(0, 0, 1, 1, 4'h7), 1);
        add(mk(0, 0, 0, 1, 4'h7), 4);
        add(mk(0, 0, 1, 0, 4'h8), 1);
        add(mk(0, 0, 0, 0, 4'h8), 3);
        add(mk(0, 0, 1, 1, 4'h9), 1);
        add(mk(0, 1, 0, 1, 4'h9), 1);
        add(mk(0, 0, 0, 1, 4'h9), 4);
        add(mk(0, 1, 0, 1, 4'h9), 2);
        n = stim_q.size();
        for (int k = 0; k < n; k++) begin
            apply(stim_q[k]);
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (obs[i] !== mdl(i)) begin
                    n_bad++;
                    $display("FAIL b2b_model inst%0d step%0d: got %h want %h", i, k, obs[i], mdl(i));
                end
            end
            if (k == 13) begin
                n_cmp++;
                if (obs[0][11:3] !== {8'h76, 1'b1}) begin
                    n_bad++;
                    $display("FAIL b2b_first inst0: got %h want 76 valid", obs[0][11:3]);
                end
            end
            if (k == 14) begin
                n_cmp++;
                if (obs[0][11:1] !== {8'h98, 3'b100}) begin
                    n_bad++;
                    $display("FAIL b2b_refill inst0: got %h want 98 valid no-ovf", obs[0][11:1]);
                end
            end
            if (k == 17) begin
                n_cmp++;
                if (obs[1][11:1] !== {8'h98, 3'b100}) begin
                    n_bad++;
                    $display("FAIL b2b_refill inst1: got %h want 98 valid no-ovf", obs[1][11:1]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_word();
        int vcnt[2];
        int n;
        vcnt = '{0, 0};
        stim_q.delete();
        add(mk(0, 1, 1, 0, 4'hE), 1);
        add(mk(0, 1, 0, 0, 4'hE), 3);
        n = stim_q.size();
        for (int k = 0; k < n; k++) apply(stim_q[k]);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (obs[i] !== mdl(i) || obs[i][0] !== 1'b1) begin
                n_bad++;
                $display("FAIL rst_pre inst%0d: got %h want %h in EXPECT_HI", i, obs[i], mdl(i));
            end
        end
        #2 reset_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (obs[i] !== 12'h000) begin
                n_bad++;
                $display("FAIL rst_async inst%0d: got %h want 000", i, obs[i]);
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
        stim_q.delete();
        add(mk(0, 1, 0, 0, 4'h0), 4);
        add(mk(0, 1, 1, 1, 4'hD), 1);
        add(mk(0, 1, 0, 1, 4'hD), 5);
        n = stim_q.size();
        for (int k = 0; k < n; k++) begin
            apply(stim_q[k]);
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (obs[i] !== mdl(i)) begin
                    n_bad++;
                    $display("FAIL rst_model inst%0d step%0d: got %h want %h", i, k, obs[i], mdl(i));
                end
                if (obs[i][3]) vcnt[i]++;
            end
        end
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (obs[i][2] !== 1'b1 || vcnt[i] != 0) begin
                n_bad++;
                $display("FAIL rst_seq inst%0d: seq %b valid_cycles %0d want 1 0", i, obs[i][2], vcnt[i]);
            end
        end
    endtask

    task automatic test_random();
        logic sel_r;
        sel_r = mux_sel;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) sel_r = ~sel_r;
            apply(mk($urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7,
                     $urandom_range(0, 9) < 3, sel_r, 4'($urandom_range(0, 15))));
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (obs[i] !== mdl(i)) begin
                    n_bad++;
                    $display("FAIL random_model inst%0d step%0d: got %h want %h", i, k, obs[i], mdl(i));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_settle();
        test_seq_err();
        test_overflow();
        test_back_to_back();
        test_reset_mid_word();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nibble_demux_rx.md
# nibble_demux_rx

Receiving end of the 4-bit time-multiplexed bus driven by the quad 2:1 multiplexer (74157) stage: the transmitter steers a low nibble (select = 0, A side) then a high nibble (select = 1, B side) onto a shared 4-bit bus. This block samples the bus, waits out the multiplexer's select-to-output settle time, and reassembles each low/high nibble pair into an 8-bit word. It presents each word through a one-entry valid/ready output register and flags protocol errors; it sits between the multiplexed bus and the CPU's 8-bit internal data path.

## Interface

- SETTLE, default 2: clock cycles the bus must be held after any change of mux_sel before it may be sampled; 0 disables settling.
- clk  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- bus  input  4  multiplexed nibble from the 2:1 mux outputs.
- mux_sel  input  1  the transmitter's select line: 0 = low nibble, 1 = high nibble.
- strobe  input  1  single-cycle pulse: the nibble on bus for the current mux_sel is intended.
- word  output  8  assembled word, {high, low}.
- word_valid  output  1  word holds an unconsumed result.
- word_ready  input  1  consumer accepts word this cycle when word_valid && word_ready.
- seq_err  output  1  sticky: out-of-order nibble seen.
- ovf_err  output  1  sticky: completed word lost because the output register was full.
- err_clr  input  1  synchronous clear of both sticky flags.

## Operation

- Reset (async, reset_n = 0): state = EXPECT_LO; lo_reg = 0; word = 8'h00; word_valid = 0; seq_err = 0; ovf_err = 0; settle counter = SETTLE; pending = 0.
- Settle counter: loads SETTLE on any cycle where mux_sel differs from its value registered on the previous cycle; otherwise decrements to 0 and holds there. The bus is "settled" when the counter is 0.
- Strobe while settled: the nibble is taken this cycle. Strobe while not settled: pending is set and the sample is taken on the first cycle the counter reaches 0, using the bus and mux_sel values on that cycle. A second strobe while pending sets seq_err; pending stays at one entry.
- FSM, on a taken nibble:
  - EXPECT_LO, sel = 0: lo_reg <= bus; go to EXPECT_HI.
  - EXPECT_LO, sel = 1: seq_err <= 1; nibble is discarded; stay in EXPECT_LO.
  - EXPECT_HI, sel = 1: the word {bus, lo_reg} completes; go to EXPECT_LO.
  - EXPECT_HI, sel = 0: seq_err <= 1; lo_reg <= bus (resynchronize); stay in EXPECT_HI.
- Completed word: loaded into word, and word_valid set, if word_valid = 0 or the current word is consumed in the same cycle. Otherwise the new word is dropped, ovf_err <= 1, and the old word is kept.
- Consume: word_valid && word_ready with no new completion clears word_valid. word keeps its last value.
- err_clr clears both sticky flags. If an error is raised in the same cycle as err_clr, the set wins.

## Timing

- SETTLE = 0, strobe on the high nibble at edge N: word and word_valid are visible after edge N+1. Total latency is one cycle.
- mux_sel changes at edge N, strobe the same cycle: the sample is taken at edge N+SETTLE. The word appears one cycle after that.
- Maximum throughput: one word every two strobes. With SETTLE = k, one nibble per k+1 cycles when mux_sel toggles every nibble.
- word_valid can stay asserted continuously while completions and consumes coincide.
- Reset asserted mid-word: the partial lo_reg and any pending sample are lost. Outputs go to their reset values immediately, without waiting for clk.

## Structure

- Shared package ttl_pkg: FSM state encodings (EXPECT_LO = 1'b0, EXPECT_HI = 1'b1) and the default settle constant.
- One natural sub-module: settle_timer (registered mux_sel, change detect, down-counter, settled output), reusable by other receivers on multiplexed TTL buses.
- The rest is flat: FSM, lo_reg, output register, error flags.

## Test plan

- SETTLE = 0. strobe sel = 0 with bus = 4'hA, then sel = 1 with bus = 4'h5, word_ready = 1 -> word = 8'h5A, word_valid high for exactly one cycle, no errors.
- SETTLE = 2. mux_sel toggles with strobe in the same cycle -> sample taken 2 cycles later. A bus value changed during settling is ignored and the settled value is captured.
- Strobe sel = 1 in EXPECT_LO -> seq_err = 1, no word. A following normal lo = 3, hi = C pair yields 8'hC3.
- word_ready held 0 while two pairs complete (8'h11, 8'h22) -> word stays 8'h11 and ovf_err = 1. err_clr then clears the flag.
- Completion and consume in the same cycle -> word_valid stays 1, word updates, ovf_err stays 0.
- reset_n pulsed low after only the low nibble -> all outputs are reset asynchronously, and the next hi strobe raises seq_err.
